// File: rtl/t01_drop_ctrl_if.sv
// t01_drop_ctrl_if: game-mode, divider tick, board and spawn handshakes for the drop controller
interface t01_drop_ctrl_if;
  logic [1:0] top_level_state;
  logic       drop_tick_n;
  logic       soft_drop;
  logic       hard_drop;
  logic       move_reset;
  logic       drop_done;
  logic       drop_blocked;
  logic       clear_done;
  logic       spawn_ack;
  logic       spawn_fail;
  logic       drop_req;
  logic       lock_piece;
  logic       spawn_req;
  logic       speed_up;
  logic       game_over;
  logic [2:0] state_dbg;
  modport master (
    output top_level_state, drop_tick_n, soft_drop, hard_drop, move_reset,
           drop_done, drop_blocked, clear_done, spawn_ack, spawn_fail,
    input  drop_req, lock_piece, spawn_req, speed_up, game_over, state_dbg
  );
  modport slave (
    input  top_level_state, drop_tick_n, soft_drop, hard_drop, move_reset,
           drop_done, drop_blocked, clear_done, spawn_ack, spawn_fail,
    output drop_req, lock_piece, spawn_req, speed_up, game_over, state_dbg
  );
endinterface

// File: rtl/t01_drop_ctrl.sv
// t01_drop_ctrl: gravity, lock-delay, spawn sequencing and game-over control for the falling piece
module t01_drop_ctrl #(
  parameter int LOCK_TICKS = 2,
  parameter int MAX_RESETS = 8
) (
  input logic             clk,
  input logic             rst,
  t01_drop_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, SPAWN, FALL, DROP, LOCK_WAIT, LOCK, CLEAR, OVER
  } state_t;
  state_t     state, nxt;
  logic [3:0] lock_cnt, lock_nxt, reset_cnt, reset_nxt;
  logic       hard_mode, hard_nxt, tick_prev, drop_req_q, speed_q;
  logic       tick_evt, play;
  assign play     = bus.top_level_state == 2'b01;
  assign tick_evt = tick_prev & ~bus.drop_tick_n;
  // next state and counter updates; abort out of play overrides everything
  always_comb begin
    nxt       = state;
    lock_nxt  = lock_cnt;
    reset_nxt = reset_cnt;
    hard_nxt  = hard_mode;
    case (state)
      IDLE:  nxt = play ? SPAWN : IDLE;
      SPAWN: if (bus.spawn_ack) begin
        nxt       = bus.spawn_fail ? OVER : FALL;
        lock_nxt  = '0;
        reset_nxt = '0;
        hard_nxt  = 1'b0;
      end
      FALL: if (bus.hard_drop) begin
        nxt      = DROP;
        hard_nxt = 1'b1;
      end else if (tick_evt) nxt = DROP;
      DROP: if (bus.drop_done) begin
        nxt      = bus.drop_blocked ? (hard_mode ? LOCK : LOCK_WAIT) : (hard_mode ? DROP : FALL);
        lock_nxt = '0;
      end
      LOCK_WAIT: if (bus.move_reset && reset_cnt < 4'(MAX_RESETS)) begin
        reset_nxt = reset_cnt + 4'd1;
        lock_nxt  = '0;
        nxt       = FALL;
      end else if (bus.hard_drop) nxt = LOCK;
      else if (tick_evt) begin
        lock_nxt = lock_cnt + 4'd1;
        nxt      = (lock_cnt + 4'd1 == 4'(LOCK_TICKS)) ? LOCK : LOCK_WAIT;
      end
      LOCK:  nxt = CLEAR;
      CLEAR: nxt = bus.clear_done ? SPAWN : CLEAR;
      OVER:  nxt = play ? OVER : IDLE;
      default: nxt = IDLE;
    endcase
    if (!play && state != IDLE && state != OVER) begin
      nxt       = IDLE;
      lock_nxt  = '0;
      reset_nxt = '0;
      hard_nxt  = 1'b0;
    end
  end
  // state, counters, tick history and registered request outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lock_cnt   <= '0;
      reset_cnt  <= '0;
      hard_mode  <= 1'b0;
      tick_prev  <= 1'b0;
      drop_req_q <= 1'b0;
      speed_q    <= 1'b0;
    end else begin
      state      <= nxt;
      lock_cnt   <= lock_nxt;
      reset_cnt  <= reset_nxt;
      hard_mode  <= hard_nxt;
      tick_prev  <= bus.drop_tick_n;
      drop_req_q <= nxt == DROP && !(state == DROP && bus.drop_done);
      speed_q    <= bus.soft_drop && (state inside {FALL, DROP, LOCK_WAIT});
    end
  end
  assign bus.drop_req   = drop_req_q;
  assign bus.lock_piece = state == LOCK;
  assign bus.spawn_req  = state == SPAWN;
  assign bus.game_over  = state == OVER;
  assign bus.speed_up   = speed_q;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_t01_drop_ctrl.sv
// tb_t01_drop_ctrl: directed checks of fall, lock delay, lock resets, hard drop, game over and abort
module tb_t01_drop_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   rises = 0;
  logic req_q = 1'b0;
  t01_drop_ctrl_if bus ();
  t01_drop_ctrl #(.LOCK_TICKS(2), .MAX_RESETS(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.drop_req && !req_q) rises++;
    req_q = bus.drop_req;
  end
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic tick();
    bus.drop_tick_n = 1'b1;
    step();
    bus.drop_tick_n = 1'b0;
    step();
    bus.drop_tick_n = 1'b1;
  endtask
  task automatic wait_req();
    int n = 0;
    while (!bus.drop_req && n < 40) begin
      step();
      n++;
    end
    if (!bus.drop_req) chk("req_timeout", 8'(bus.drop_req), 8'd1);
  endtask
  task automatic done(input logic blk);
    bus.drop_done = 1'b1;
    bus.drop_blocked = blk;
    step();
    bus.drop_done = 1'b0;
    bus.drop_blocked = 1'b0;
  endtask
  task automatic spawn(input logic fail);
    int n = 0;
    while (!bus.spawn_req && n < 40) begin
      step();
      n++;
    end
    if (!bus.spawn_req) chk("spawn_timeout", 8'(bus.spawn_req), 8'd1);
    bus.spawn_ack = 1'b1;
    bus.spawn_fail = fail;
    step();
    bus.spawn_ack = 1'b0;
    bus.spawn_fail = 1'b0;
  endtask
  task automatic clear();
    bus.clear_done = 1'b1;
    step();
    bus.clear_done = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.top_level_state = 2'b00;
    bus.drop_tick_n = 1'b0;
    bus.soft_drop = 1'b0;
    bus.hard_drop = 1'b0;
    bus.move_reset = 1'b0;
    bus.drop_done = 1'b0;
    bus.drop_blocked = 1'b0;
    bus.clear_done = 1'b0;
    bus.spawn_ack = 1'b0;
    bus.spawn_fail = 1'b0;
    step(3);
    chk("rst_state", 8'(bus.state_dbg), 8'd0);
    chk("rst_outs", {3'b0, bus.drop_req, bus.lock_piece, bus.spawn_req, bus.speed_up, bus.game_over}, 8'd0);
    rst = 1'b0;
    bus.top_level_state = 2'b01;
    step();
    chk("spawn_req", 8'(bus.spawn_req), 8'd1);
    spawn(1'b0);
    chk("fall_state", 8'(bus.state_dbg), 8'd2);
    chk("spawn_req_low", 8'(bus.spawn_req), 8'd0);
    step(5);
    chk("no_spurious_tick", 8'(bus.drop_req), 8'd0);
    tick();
    chk("tick_req", 8'(bus.drop_req), 8'd1);
    chk("drop_state", 8'(bus.state_dbg), 8'd3);
    step(2);
    done(1'b0);
    chk("req_fall", 8'(bus.drop_req), 8'd0);
    chk("back_fall", 8'(bus.state_dbg), 8'd2);
    bus.soft_drop = 1'b1;
    step();
    chk("speed_on", 8'(bus.speed_up), 8'd1);
    bus.soft_drop = 1'b0;
    step();
    chk("speed_off", 8'(bus.speed_up), 8'd0);
    step(15);
    tick();
    chk("tick_req2", 8'(bus.drop_req), 8'd1);
    step(2);
    done(1'b0);
    chk("req_fall2", 8'(bus.drop_req), 8'd0);
    chk("no_lock", 8'(bus.lock_piece), 8'd0);
    tick();
    done(1'b1);
    chk("lock_wait", 8'(bus.state_dbg), 8'd4);
    tick();
    chk("lw_one_tick", {bus.state_dbg, 4'b0, bus.lock_piece}, {3'd4, 5'd0});
    tick();
    chk("lock_pulse", 8'(bus.lock_piece), 8'd1);
    chk("lock_state", 8'(bus.state_dbg), 8'd5);
    step();
    chk("lock_end", {bus.state_dbg, 4'b0, bus.lock_piece}, {3'd6, 5'd0});
    tick();
    chk("clear_ign_tick", 8'(bus.state_dbg), 8'd6);
    clear();
    chk("respawn", 8'(bus.spawn_req), 8'd1);
    spawn(1'b0);
    tick();
    done(1'b1);
    bus.move_reset = 1'b1;
    step();
    bus.move_reset = 1'b0;
    chk("mr1", 8'(bus.state_dbg), 8'd2);
    tick();
    done(1'b1);
    bus.move_reset = 1'b1;
    step();
    bus.move_reset = 1'b0;
    chk("mr2", 8'(bus.state_dbg), 8'd2);
    tick();
    done(1'b1);
    bus.move_reset = 1'b1;
    step();
    bus.move_reset = 1'b0;
    chk("mr3_ignored", 8'(bus.state_dbg), 8'd4);
    tick();
    chk("mr3_tick1", 8'(bus.state_dbg), 8'd4);
    tick();
    chk("mr3_lock", 8'(bus.lock_piece), 8'd1);
    step();
    clear();
    spawn(1'b0);
    tick();
    done(1'b1);
    bus.drop_tick_n = 1'b1;
    step();
    bus.drop_tick_n = 1'b0;
    bus.move_reset = 1'b1;
    step();
    bus.drop_tick_n = 1'b1;
    bus.move_reset = 1'b0;
    chk("mr_beats_tick", 8'(bus.state_dbg), 8'd2);
    step();
    bus.drop_tick_n = 1'b0;
    bus.hard_drop = 1'b1;
    rises = 0;
    step();
    bus.drop_tick_n = 1'b1;
    bus.hard_drop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_req();
      done(1'b0);
      chk($sformatf("hard_gap%0d", i), 8'(bus.drop_req), 8'd0);
    end
    wait_req();
    done(1'b1);
    chk("hard_lock", 8'(bus.lock_piece), 8'd1);
    chk("hard_rises", 8'(rises), 8'd5);
    step();
    clear();
    spawn(1'b1);
    chk("game_over", {bus.state_dbg, 4'b0, bus.game_over}, {3'd7, 5'd1});
    step(3);
    chk("over_held", 8'(bus.game_over), 8'd1);
    bus.top_level_state = 2'b00;
    step();
    chk("over_idle", {bus.state_dbg, 4'b0, bus.game_over}, 8'd0);
    bus.top_level_state = 2'b01;
    step();
    spawn(1'b0);
    tick();
    chk("abort_pre", 8'(bus.drop_req), 8'd1);
    bus.top_level_state = 2'b10;
    step();
    chk("abort_req", 8'(bus.drop_req), 8'd0);
    chk("abort_state", 8'(bus.state_dbg), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/t01_drop_ctrl.md
# t01_drop_ctrl

Gravity and lock controller for the falling piece. It consumes the active-low one-cycle drop tick from the game clock divider and turns each tick into a move-down request to the board/collision logic. It runs the lock-delay and lock-reset rules, sequences lock, line-clear wait and next-piece spawn, and flags game over. It also drives `speed_up` back into the divider while soft drop is held.

## Interface
Parameters:
- `LOCK_TICKS`, default 2: drop ticks spent resting on a surface before the piece locks; range 1..15.
- `MAX_RESETS`, default 8: lateral-move lock resets allowed per piece; range 0..15.

Ports (reset `rst` is asynchronous, active-high; clock is `clk`):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `top_level_state`  in  2  game mode; 2'b01 = play, all other values = not playing
- `drop_tick_n`  in  1  divider tick: normally high, low for exactly one cycle per period
- `soft_drop`  in  1  soft-drop button level, already debounced
- `hard_drop`  in  1  one-cycle hard-drop pulse
- `move_reset`  in  1  one-cycle pulse: a lateral move or rotation succeeded
- `drop_done`  in  1  one-cycle pulse: board finished evaluating `drop_req`
- `drop_blocked`  in  1  qualified by `drop_done`; 1 = piece could not move down
- `clear_done`  in  1  one-cycle pulse: line clear and score update complete
- `spawn_ack`  in  1  one-cycle pulse: spawn attempt finished
- `spawn_fail`  in  1  qualified by `spawn_ack`; 1 = spawn position is occupied
- `drop_req`  out  1  level: move piece down one row; held until `drop_done`
- `lock_piece`  out  1  one-cycle pulse: write the piece into the board
- `spawn_req`  out  1  level: spawn the next piece; held until `spawn_ack`
- `speed_up`  out  1  soft-drop request to the divider
- `game_over`  out  1  sticky level while in the OVER state
- `state_dbg`  out  3  current FSM state encoding

## Operation
- Tick detect:
  - `tick_prev` is a register of `drop_tick_n`, reset to 0.
  - `tick_evt = tick_prev & ~drop_tick_n`.
  - Reset value 0 guarantees no spurious tick when the divider leaves reset low.
- FSM states: IDLE=0, SPAWN=1, FALL=2, DROP=3, LOCK_WAIT=4, LOCK=5, CLEAR=6, OVER=7.
- IDLE: if `top_level_state==2'b01`, go to SPAWN.
- SPAWN:
  - `spawn_req`=1.
  - `spawn_ack & ~spawn_fail`: go to FALL; clear `reset_cnt`, `lock_cnt` and `hard_mode`.
  - `spawn_ack & spawn_fail`: go to OVER.
- FALL:
  - `tick_evt`: go to DROP.
  - `hard_drop`: go to DROP and set `hard_mode`.
- DROP:
  - `drop_req`=1.
  - `drop_done & ~drop_blocked`: go to DROP if `hard_mode`, else FALL.
  - `drop_done & drop_blocked`: go to LOCK if `hard_mode`, else LOCK_WAIT with `lock_cnt`=0.
- LOCK_WAIT:
  - `move_reset` with `reset_cnt<MAX_RESETS`: `reset_cnt`+1, `lock_cnt`=0, go to FALL. The next tick re-probes the board.
  - Otherwise `tick_evt`: `lock_cnt`+1; go to LOCK when the new value equals `LOCK_TICKS`.
  - `hard_drop`: go to LOCK immediately.
- LOCK: `lock_piece`=1 for this one cycle, then go to CLEAR.
- CLEAR: `clear_done` goes to SPAWN.
- OVER: `game_over`=1; stays in OVER until `top_level_state!=2'b01`, then goes to IDLE.
- Abort rule: in any state other than IDLE or OVER, `top_level_state!=2'b01` forces IDLE at the next edge. All counters and `hard_mode` clear. The board must tolerate a withdrawn `drop_req`/`spawn_req`.
- `speed_up = soft_drop & (state is FALL, DROP or LOCK_WAIT)`. It is registered, so it follows the inputs by 1 cycle.
- Counters are 4 bits. `reset_cnt` saturates at `MAX_RESETS`. `move_reset` at saturation is ignored.
- `tick_evt` is ignored (never queued) in every state except FALL and LOCK_WAIT.
- `hard_drop` is ignored outside FALL and LOCK_WAIT.

## Timing
- Reset values: state IDLE; `drop_req`, `lock_piece`, `spawn_req`, `speed_up`, `game_over` all 0; `state_dbg`=0; `tick_prev`=0; counters 0.
- All outputs are registered and decoded from the state. The state changes on the edge where the qualifying input is high. The output is visible in the following cycle.
- Tick to `drop_req`: 1 cycle after the cycle in which `drop_tick_n` is low.
- `drop_done` to `drop_req` low: 1 cycle. In hard mode `drop_req` deasserts for exactly 1 cycle (FALL is bypassed; DROP→DROP re-entry shows as 1 low cycle) and then reasserts.
- Simultaneous events:
  - `move_reset` and `tick_evt` in LOCK_WAIT: `move_reset` wins and the tick is not counted.
  - `hard_drop` and `tick_evt` in FALL: hard drop wins.
  - Abort wins over every other transition.
- `lock_piece` is high for exactly 1 cycle per locked piece.

## Test plan
- Normal fall: play state, ticks every 20 cycles, board answers `drop_done` with blocked=0 after 3 cycles → `drop_req` rises 1 cycle after each tick and falls 1 cycle after `drop_done`; no `lock_piece`.
- Lock delay: blocked=1 on a tick, `LOCK_TICKS`=2 → state LOCK_WAIT; after 2 further ticks, one `lock_piece` pulse, then CLEAR; `clear_done` → `spawn_req`=1.
- Lock resets: `MAX_RESETS`=2, blocked each time, `move_reset` pulsed in LOCK_WAIT 3 times → first 2 return to FALL; the 3rd is ignored and the lock occurs 2 ticks later.
- Hard drop: `hard_drop` in FALL, board reports unblocked 4 times then blocked → 5 `drop_req` assertions with no tick needed; `lock_piece` 1 cycle after the blocked `drop_done`.
- Game over and abort: `spawn_ack` with `spawn_fail`=1 → `game_over`=1, held; `top_level_state`→2'b00 → IDLE, `game_over`=0. Separately, `top_level_state`→2'b10 mid-DROP → `drop_req`=0 next cycle, `state_dbg`=0.
- Reset/tick edge: assert `rst` with `drop_tick_n`=0 and release → no `drop_req` until the first genuine high→low transition of `drop_tick_n`.
